led_step_seq: RTL and testbench

Step sequencer that drives the 7-bit step index consumed by the LED pattern decoder (10-bit bar, 128-entry animation table). It divides the system clock into animation ticks and walks the index 0..127 in loop, ping-pong or one-shot order, with start/stop control and a per-step strobe. It sits between the board control inputs and the decoder input `i`; `step` connects directly to that input.

---
 rtl/led_step_seq_if.sv | 22 ++
 rtl/led_step_seq.sv | 153 +++++++++++++++
 tb/tb_led_step_seq.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/led_step_seq_if.sv
// Control/status bundle between the board controls, led_step_seq and the LED
// pattern decoder. The master drives control inputs; the slave is the sequencer.
interface led_step_seq_if;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [1:0] speed;
  logic [6:0] step;
  logic       tick;
  logic       busy;
  logic       done;

  modport master (
    output start, stop, mode, speed,
    input  step, tick, busy, done
  );

  modport slave (
    input  start, stop, mode, speed,
    output step, tick, busy, done
  );
endinterface

// File: rtl/led_step_seq.sv
// Animation step sequencer: prescales clk into ticks and walks the decoder step
// index 0..LAST in loop, ping-pong or one-shot order.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   S_IDLE | halted; step held, prescaler parked at 0, waiting for start
//   S_RUN  | prescaler running; step advances on every prescaler expiry
module led_step_seq #(
  parameter int DIV  = 5_000_000,
  parameter int LAST = 127
) (
  input  logic          clk,
  input  logic          rst_n,
  led_step_seq_if.slave bus
);

  localparam int            PW     = $clog2(DIV) + 1;
  localparam logic [PW-1:0] DIV_W  = PW'(DIV);
  localparam logic [6:0]    LAST_W = 7'(LAST);

  localparam logic [1:0] MODE_LOOP = 2'b00;
  localparam logic [1:0] MODE_PING = 2'b01;
  localparam logic [1:0] MODE_ONE  = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_presc;
  logic [6:0]    r_step;
  logic          r_dir_up;
  logic [1:0]    r_mode;
  logic          r_tick;
  logic          r_busy;
  logic          r_done;

  logic [PW-1:0] w_shifted;
  logic [PW-1:0] w_last_cnt;
  logic          w_expire;
  logic [6:0]    w_next_step;
  logic          w_next_dir_up;
  logic          w_finish;

  // Terminal count follows the live speed input; the >= compare lets a
  // shortened period expire immediately instead of wrapping the counter.
  always_comb begin
    w_shifted  = DIV_W >> bus.speed;
    w_last_cnt = (w_shifted == '0) ? '0 : (w_shifted - PW'(1));
  end

  assign w_expire = (r_presc >= w_last_cnt);

  always_comb begin
    w_next_step   = r_step;
    w_next_dir_up = r_dir_up;
    w_finish      = 1'b0;
    case (r_mode)
      MODE_PING: begin
        // Endpoints are shown once per pass: turn around without repeating.
        if (r_dir_up) begin
          if (r_step >= LAST_W) begin
            w_next_dir_up = 1'b0;
            w_next_step   = LAST_W - 7'd1;
          end else begin
            w_next_step = r_step + 7'd1;
          end
        end else begin
          if (r_step == 7'd0) begin
            w_next_dir_up = 1'b1;
            w_next_step   = 7'd1;
          end else begin
            w_next_step = r_step - 7'd1;
          end
        end
      end
      MODE_ONE: begin
        if (r_step >= LAST_W) begin
          w_finish = 1'b1;
        end else begin
          w_next_step = r_step + 7'd1;
        end
      end
      default: begin
        w_next_step = (r_step >= LAST_W) ? 7'd0 : (r_step + 7'd1);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_presc  <= '0;
      r_step   <= 7'd0;
      r_dir_up <= 1'b1;
      r_mode   <= MODE_LOOP;
      r_tick   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_presc <= '0;
          if (bus.start && !bus.stop) begin
            r_state  <= S_RUN;
            r_step   <= 7'd0;
            r_dir_up <= 1'b1;
            r_mode   <= bus.mode;
            r_busy   <= 1'b1;
          end
        end
        S_RUN: begin
          if (bus.stop) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_busy  <= 1'b0;
          end else if (bus.start) begin
            r_presc  <= '0;
            r_step   <= 7'd0;
            r_dir_up <= 1'b1;
            r_mode   <= bus.mode;
          end else if (w_expire) begin
            r_presc <= '0;
            if (w_finish) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_step   <= w_next_step;
              r_dir_up <= w_next_dir_up;
              r_tick   <= 1'b1;
            end
          end else begin
            r_presc <= r_presc + PW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.step = r_step;
  assign bus.tick = r_tick;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_led_step_seq.sv
// Scoreboard bench for led_step_seq: stimulus queues expected tick/done events
// with their cycle stamps, per-DUT monitors pop and compare on every event.
module tb_led_step_seq;

  typedef struct {
    int         cyc;
    logic [6:0] step;
    logic       tick;
    logic       busy;
    logic       done;
  } evt_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_err;
  evt_t q_a[$];
  evt_t q_b[$];

  led_step_seq_if ifa ();
  led_step_seq_if ifb ();

  led_step_seq #(.DIV(4),  .LAST(127)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  led_step_seq #(.DIV(16), .LAST(127)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d (cyc=%0d)", nm, act, req, cyc);
    end
  endtask

  task automatic check_evt(input string nm, input evt_t e, input int c,
                           input logic [6:0] s, input logic t, input logic b, input logic d);
    n_chk++;
    if (c != e.cyc || s !== e.step || t !== e.tick || b !== e.busy || d !== e.done) begin
      n_err++;
      $display("FAIL %s actual cyc=%0d step=%0d tick=%0b busy=%0b done=%0b required cyc=%0d step=%0d tick=%0b busy=%0b done=%0b",
               nm, c, s, t, b, d, e.cyc, e.step, e.tick, e.busy, e.done);
    end
  endtask

  always @(negedge clk) begin
    if (ifa.tick === 1'b1 || ifa.done === 1'b1) begin
      if (q_a.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL evt_a_unexpected actual cyc=%0d step=%0d tick=%0b done=%0b required no event",
                 cyc, ifa.step, ifa.tick, ifa.done);
      end else begin
        check_evt("evt_a", q_a.pop_front(), cyc, ifa.step, ifa.tick, ifa.busy, ifa.done);
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.tick === 1'b1 || ifb.done === 1'b1) begin
      if (q_b.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL evt_b_unexpected actual cyc=%0d step=%0d tick=%0b done=%0b required no event",
                 cyc, ifb.step, ifb.tick, ifb.done);
      end else begin
        check_evt("evt_b", q_b.pop_front(), cyc, ifb.step, ifb.tick, ifb.busy, ifb.done);
      end
    end
  end

  task automatic push_a(input int c, input int s, input logic t, input logic b, input logic d);
    evt_t e;
    e.cyc = c; e.step = 7'(s); e.tick = t; e.busy = b; e.done = d;
    q_a.push_back(e);
  endtask

  task automatic push_b(input int c, input int s);
    evt_t e;
    e.cyc = c; e.step = 7'(s); e.tick = 1'b1; e.busy = 1'b1; e.done = 1'b0;
    q_b.push_back(e);
  endtask

  // Leaves the caller at the negedge just before posedge number e.
  task automatic wait_edge(input int e);
    int guard;
    guard = 0;
    if (cyc > e - 1) begin
      n_chk++;
      n_err++;
      $display("FAIL sched actual cyc=%0d required edge>%0d", cyc, cyc);
    end
    while (cyc < e - 1 && guard < 50000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // Drives start/stop so they are sampled exactly at posedge e; returns at the negedge after it.
  task automatic pulse(input bit on_b, input bit s_start, input bit s_stop, input int e);
    wait_edge(e);
    if (on_b) begin ifb.start = s_start; ifb.stop = s_stop; end
    else      begin ifa.start = s_start; ifa.stop = s_stop; end
    @(negedge clk);
    ifa.start = 1'b0; ifa.stop = 1'b0;
    ifb.start = 1'b0; ifb.stop = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int s;
    bit up;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    ifa.start = 0; ifa.stop = 0; ifa.mode = 2'b00; ifa.speed = 2'b00;
    ifb.start = 0; ifb.stop = 0; ifb.mode = 2'b00; ifb.speed = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_step", ifa.step, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_tick", ifa.tick, 0);
    chk("rst_done", ifa.done, 0);

    // Loop, P=4: 0..127 then wrap to 0, 1; stop away from an expiry
    ifa.mode = 2'b00; ifa.speed = 2'b00;
    n = cyc + 2;
    for (int k = 1; k <= 129; k++) push_a(n + 4 * k, k % 128, 1'b1, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, n);
    chk("loop_start_busy", ifa.busy, 1);
    chk("loop_start_step", ifa.step, 0);
    pulse(1'b0, 1'b0, 1'b1, n + 4 * 129 + 2);
    chk("loop_stop_busy", ifa.busy, 0);
    chk("loop_stop_step", ifa.step, 1);
    chk("loop_drained", q_a.size(), 0);

    // Ping-pong, P=1: turnaround at both ends without repeats
    ifa.mode = 2'b01; ifa.speed = 2'b10;
    n = cyc + 2;
    s = 0; up = 1'b1;
    for (int k = 1; k <= 256; k++) begin
      if (up) begin
        if (s == 127) begin up = 1'b0; s = 126; end else s = s + 1;
      end else begin
        if (s == 0) begin up = 1'b1; s = 1; end else s = s - 1;
      end
      push_a(n + k, s, 1'b1, 1'b1, 1'b0);
    end
    pulse(1'b0, 1'b1, 1'b0, n);
    pulse(1'b0, 1'b0, 1'b1, n + 257);
    chk("ping_stop_step", ifa.step, 2);
    chk("ping_stop_busy", ifa.busy, 0);
    chk("ping_drained", q_a.size(), 0);
    ifa.speed = 2'b00;

    // One-shot, P=4: done P cycles after reaching 127, no tick on that edge
    ifa.mode = 2'b10;
    n = cyc + 2;
    for (int k = 1; k <= 127; k++) push_a(n + 4 * k, k, 1'b1, 1'b1, 1'b0);
    push_a(n + 512, 127, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 1'b1, 1'b0, n);
    wait_edge(n + 521);
    chk("oneshot_step", ifa.step, 127);
    chk("oneshot_busy", ifa.busy, 0);
    chk("oneshot_drained", q_a.size(), 0);

    // Stop on an expiry cycle at step 40, then start+stop together
    ifa.mode = 2'b00;
    n = cyc + 2;
    for (int k = 1; k <= 40; k++) push_a(n + 4 * k, k, 1'b1, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, n);
    pulse(1'b0, 1'b0, 1'b1, n + 164);
    chk("stop_exp_step", ifa.step, 40);
    chk("stop_exp_busy", ifa.busy, 0);
    chk("stop_exp_tick", ifa.tick, 0);
    pulse(1'b0, 1'b1, 1'b1, n + 170);
    chk("startstop_busy", ifa.busy, 0);
    chk("startstop_step", ifa.step, 40);
    wait_edge(n + 190);
    chk("stop_drained", q_a.size(), 0);

    // DIV=16: speed drops to P=4 with prescaler at 10 -> expire next edge
    ifb.mode = 2'b00; ifb.speed = 2'b00;
    n = cyc + 2;
    push_b(n + 11, 1);
    push_b(n + 15, 2);
    push_b(n + 19, 3);
    pulse(1'b1, 1'b1, 1'b0, n);
    wait_edge(n + 11);
    ifb.speed = 2'b10;
    pulse(1'b1, 1'b0, 1'b1, n + 21);
    chk("speed_step", ifb.step, 3);
    chk("speed_busy", ifb.busy, 0);
    chk("speed_drained", q_b.size(), 0);
    ifb.speed = 2'b00;

    // Asynchronous reset mid-run at step 77
    ifa.mode = 2'b00;
    n = cyc + 2;
    for (int k = 1; k <= 77; k++) push_a(n + 4 * k, k, 1'b1, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, n);
    wait_edge(n + 310);
    chk("pre_rst_step", ifa.step, 77);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_step", ifa.step, 0);
    chk("arst_busy", ifa.busy, 0);
    chk("arst_tick", ifa.tick, 0);
    chk("arst_done", ifa.done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_busy", ifa.busy, 0);
    chk("post_rst_step", ifa.step, 0);
    chk("post_rst_drained", q_a.size(), 0);

    n = cyc + 2;
    push_a(n + 4, 1, 1'b1, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, n);
    pulse(1'b0, 1'b0, 1'b1, n + 6);
    chk("restart_step", ifa.step, 1);
    chk("final_drained_a", q_a.size(), 0);
    chk("final_drained_b", q_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
